// File: rtl/imr_adc_axil_regs.sv
// AXI4-Lite register bank for the dual AD7476A ADC core: control/config registers
// driving the sampling engine plus result, status and sample-count registers it updates.
module imr_adc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_ADC_BITS         = 12
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              adc_enable,
  output logic                              adc_start,
  output logic [15:0]                       adc_clk_div,
  output logic [31:0]                       adc_period,
  input  logic                              adc_busy,
  input  logic                              sample_valid,
  input  logic [C_ADC_BITS-1:0]             sample_a,
  input  logic [C_ADC_BITS-1:0]             sample_b
);

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_CLKDIV  = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_SCRATCH = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_DATA    = 3'd5;
  localparam logic [2:0] REG_CNT     = 3'd6;

  // write channel state
  logic                            aw_latched_reg, w_latched_reg, bvalid_reg;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_reg;
  logic                            aw_hs, w_hs, do_write;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, wr_mask;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
  logic [2:0]                      wr_idx;

  // register file
  logic                  enable_reg, start_reg;
  logic [15:0]           clk_div_reg;
  logic [31:0]           period_reg, scratch_reg, sample_cnt_reg;
  logic [C_ADC_BITS-1:0] data_a_reg, data_b_reg;
  logic                  data_ready_reg, overrun_reg;

  // read channel state
  logic                          rvalid_reg, ar_hs, data_read;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg, rd_mux;
  logic [2:0]                    rd_idx;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], wr_addr[1:0]};

  assign S_AXI_AWREADY = !reset && !bvalid_reg && !aw_latched_reg;
  assign S_AXI_WREADY  = !reset && !bvalid_reg && !w_latched_reg;
  assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
  // Commit as soon as both halves are present, whether latched earlier or arriving now.
  assign do_write      = (aw_latched_reg || aw_hs) && (w_latched_reg || w_hs);
  assign wr_addr       = aw_latched_reg ? awaddr_reg : S_AXI_AWADDR;
  assign wr_data       = w_latched_reg ? wdata_reg : S_AXI_WDATA;
  assign wr_strb       = w_latched_reg ? wstrb_reg : S_AXI_WSTRB;
  assign wr_idx        = wr_addr[4:2];

  genvar gi;
  generate
    for (gi = 0; gi < C_S_AXI_DATA_WIDTH/8; gi++) begin : g_byte_mask
      assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      bvalid_reg     <= 1'b0;
      awaddr_reg     <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      if (bvalid_reg && S_AXI_BREADY)
        bvalid_reg <= 1'b0;
      if (do_write) begin
        aw_latched_reg <= 1'b0;
        w_latched_reg  <= 1'b0;
        bvalid_reg     <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_latched_reg <= 1'b1;
          awaddr_reg     <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_latched_reg <= 1'b1;
          wdata_reg     <= S_AXI_WDATA;
          wstrb_reg     <= S_AXI_WSTRB;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_reg  <= 1'b0;
      start_reg   <= 1'b0;
      clk_div_reg <= 16'h0004;
      period_reg  <= '0;
      scratch_reg <= '0;
    end else begin
      // CTRL[1] is a strobe only; it is never stored
      start_reg <= do_write && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[1];
      if (do_write) begin
        case (wr_idx)
          REG_CTRL:    if (wr_strb[0]) enable_reg <= wr_data[0];
          REG_CLKDIV:  clk_div_reg <= (clk_div_reg & ~wr_mask[15:0]) | (wr_data[15:0] & wr_mask[15:0]);
          REG_PERIOD:  period_reg  <= (period_reg & ~wr_mask) | (wr_data & wr_mask);
          REG_SCRATCH: scratch_reg <= (scratch_reg & ~wr_mask) | (wr_data & wr_mask);
          default: ;
        endcase
      end
    end
  end

  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx    = S_AXI_ARADDR[4:2];
  assign data_read = ar_hs && (rd_idx == REG_DATA);

  // Sample capture; a DATA read clears the flags, but a coincident strobe re-arms data_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_a_reg     <= '0;
      data_b_reg     <= '0;
      sample_cnt_reg <= '0;
      data_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (sample_valid) begin
        data_a_reg     <= sample_a;
        data_b_reg     <= sample_b;
        sample_cnt_reg <= sample_cnt_reg + 32'd1;
      end
      if (sample_valid)
        data_ready_reg <= 1'b1;
      else if (data_read)
        data_ready_reg <= 1'b0;
      if (data_read)
        overrun_reg <= 1'b0;
      else if (sample_valid && data_ready_reg)
        overrun_reg <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL:    rd_mux[0]    = enable_reg;
      REG_CLKDIV:  rd_mux[15:0] = clk_div_reg;
      REG_PERIOD:  rd_mux       = period_reg;
      REG_SCRATCH: rd_mux       = scratch_reg;
      REG_STATUS:  rd_mux[2:0]  = {overrun_reg, data_ready_reg, adc_busy};
      REG_DATA: begin
        rd_mux[C_ADC_BITS-1:0]    = data_a_reg;
        rd_mux[16 +: C_ADC_BITS]  = data_b_reg;
      end
      REG_CNT:     rd_mux       = sample_cnt_reg;
      default:     rd_mux       = '0;
    endcase
  end

  assign S_AXI_ARREADY = !reset && !rvalid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (rvalid_reg && S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign S_AXI_BVALID = bvalid_reg;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign S_AXI_RRESP  = 2'b00;
  assign adc_enable   = enable_reg;
  assign adc_start    = start_reg;
  assign adc_clk_div  = clk_div_reg;
  assign adc_period   = period_reg;

endmodule

// File: tb/tb_imr_adc_axil_regs.sv
// Directed bench for imr_adc_axil_regs: AXI-Lite write/read sequences, sample strobes,
// stall and reset-abort scenarios, each checked against hand-computed values.
module tb_imr_adc_axil_regs;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        adc_enable, adc_start;
  logic [15:0] adc_clk_div;
  logic [31:0] adc_period;
  logic        adc_busy, sample_valid;
  logic [11:0] sample_a, sample_b;

  int tests_run = 0;
  int tests_failed = 0;
  int start_cnt = 0;

  imr_adc_axil_regs dut (
    .clock(clock), .reset(reset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .adc_enable(adc_enable), .adc_start(adc_start),
    .adc_clk_div(adc_clk_div), .adc_period(adc_period),
    .adc_busy(adc_busy), .sample_valid(sample_valid),
    .sample_a(sample_a), .sample_b(sample_b)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (adc_start) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    int n = 0;
    @(negedge clock);
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      @(negedge clock);
      if (aw_done) S_AXI_AWVALID = 1'b0;
      if (w_done) S_AXI_WVALID = 1'b0;
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("wr_bvalid", 32'(S_AXI_BVALID), 32'd1);
    check("wr_bresp", 32'(S_AXI_BRESP), 32'd0);
    S_AXI_BREADY = 1'b1;
    @(negedge clock);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n = 0;
    @(negedge clock);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    S_AXI_ARVALID = 1'b0;
    check("rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
    data = S_AXI_RDATA;
    S_AXI_RREADY = 1'b1;
    @(negedge clock);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic strobe(input logic [11:0] a, input logic [11:0] b);
    @(negedge clock);
    sample_a = a; sample_b = b; sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int sc;
  logic [4:0]  addrs [4] = '{5'h00, 5'h04, 5'h08, 5'h0C};
  logic [31:0] exp_rb [4] = '{32'h1, 32'h2, 32'h3, 32'h4};

  initial begin
    reset = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    adc_busy = 1'b0; sample_valid = 1'b0; sample_a = '0; sample_b = '0;
    repeat (3) @(negedge clock);

    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_clk_div", 32'(adc_clk_div), 32'h4);
    reset = 1'b0;
    @(negedge clock);
    axi_read(5'h00, rd); check("rst_ctrl", rd, 32'h0);
    axi_read(5'h04, rd); check("rst_clkdiv", rd, 32'h4);
    axi_read(5'h08, rd); check("rst_period", rd, 32'h0);
    axi_read(5'h10, rd); check("rst_status", rd, 32'h0);
    axi_read(5'h1C, rd); check("rsvd_read", rd, 32'h0);

    // basic write/readback
    sc = start_cnt;
    for (int i = 0; i < 4; i++) axi_write(addrs[i], exp_rb[i], 4'hF);
    check("no_start_pulse", 32'(start_cnt - sc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], rd);
      check("readback", rd, exp_rb[i]);
    end
    check("adc_enable", 32'(adc_enable), 32'd1);
    check("adc_clk_div", 32'(adc_clk_div), 32'h2);
    check("adc_period", adc_period, 32'h3);

    // CTRL[1] strobe
    sc = start_cnt;
    axi_write(5'h00, 32'h3, 4'hF);
    repeat (2) @(negedge clock);
    check("start_pulses", 32'(start_cnt - sc), 32'd1);
    axi_read(5'h00, rd); check("ctrl_after_start", rd, 32'h1);

    // W three cycles ahead of AW, byte-lane strobe
    axi_write(5'h0C, 32'h0, 4'hF);
    @(negedge clock);
    S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'b0010; S_AXI_WVALID = 1'b1;
    check("w_early_ready", 32'(S_AXI_WREADY), 32'd1);
    @(negedge clock);
    S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("w_held_ready", 32'(S_AXI_WREADY), 32'd0);
      check("w_only_bvalid", 32'(S_AXI_BVALID), 32'd0);
      @(negedge clock);
    end
    S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
    check("aw_late_ready", 32'(S_AXI_AWREADY), 32'd1);
    @(negedge clock);
    S_AXI_AWVALID = 1'b0;
    check("bvalid_after_aw", 32'(S_AXI_BVALID), 32'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge clock);
    S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", 32'(S_AXI_BVALID), 32'd0);
    axi_read(5'h0C, rd); check("wstrb_scratch", rd, 32'h0000_FF00);

    // read-only targets ignore writes
    axi_write(5'h18, 32'h55, 4'hF);
    axi_read(5'h18, rd); check("cnt_ro", rd, 32'h0);

    // samples and sticky overrun
    strobe(12'h123, 12'hABC);
    strobe(12'h001, 12'hABC);
    axi_read(5'h10, rd); check("status_overrun", rd, 32'h6);
    axi_read(5'h14, rd); check("data_two", rd, 32'h0ABC_0001);
    axi_read(5'h18, rd); check("cnt_two", rd, 32'h2);
    axi_read(5'h10, rd); check("status_cleared", rd, 32'h0);
    adc_busy = 1'b1;
    axi_read(5'h10, rd); check("status_busy", rd, 32'h1);
    adc_busy = 1'b0;

    // DATA read coinciding with a new sample
    strobe(12'h055, 12'h0AA);
    @(negedge clock);
    S_AXI_ARADDR = 5'h14; S_AXI_ARVALID = 1'b1;
    sample_a = 12'h7FF; sample_b = 12'h800; sample_valid = 1'b1;
    @(negedge clock);
    S_AXI_ARVALID = 1'b0; sample_valid = 1'b0;
    check("race_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("race_old_data", S_AXI_RDATA, 32'h00AA_0055);
    S_AXI_RREADY = 1'b1;
    @(negedge clock);
    S_AXI_RREADY = 1'b0;
    axi_read(5'h10, rd); check("race_status", rd, 32'h2);
    axi_read(5'h14, rd); check("race_new_data", rd, 32'h0800_07FF);
    axi_read(5'h18, rd); check("cnt_four", rd, 32'h4);

    // back-pressure on B and R
    @(negedge clock);
    S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge clock);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("b_stall_valid", 32'(S_AXI_BVALID), 32'd1);
      check("b_stall_awready", 32'(S_AXI_AWREADY), 32'd0);
      @(negedge clock);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clock);
    S_AXI_BREADY = 1'b0;
    check("b_stall_done", 32'(S_AXI_BVALID), 32'd0);
    S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
    @(negedge clock);
    S_AXI_ARADDR = 5'h0C;
    for (int i = 0; i < 5; i++) begin
      check("r_stall_valid", 32'(S_AXI_RVALID), 32'd1);
      check("r_stall_data", S_AXI_RDATA, 32'hDEAD_BEEF);
      check("r_stall_arready", 32'(S_AXI_ARREADY), 32'd0);
      @(negedge clock);
    end
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    @(negedge clock);
    S_AXI_RREADY = 1'b0;
    check("r_stall_done", 32'(S_AXI_RVALID), 32'd0);

    // sample counter wrap
    force dut.sample_cnt_reg = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.sample_cnt_reg;
    axi_read(5'h18, rd); check("cnt_preload", rd, 32'hFFFF_FFFF);
    strobe(12'h001, 12'h002);
    axi_read(5'h18, rd); check("cnt_wrap", rd, 32'h0);

    // reset with a half-finished write
    @(negedge clock);
    S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
    @(negedge clock);
    S_AXI_AWVALID = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("mid_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("mid_rst_enable", 32'(adc_enable), 32'd0);
    check("mid_rst_clk_div", 32'(adc_clk_div), 32'h4);
    check("mid_rst_period", adc_period, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge clock);
    S_AXI_WVALID = 1'b0;
    repeat (2) @(negedge clock);
    check("aborted_aw_bvalid", 32'(S_AXI_BVALID), 32'd0);
    axi_read(5'h0C, rd); check("post_rst_scratch", rd, 32'h0);
    axi_read(5'h18, rd); check("post_rst_cnt", rd, 32'h0);
    S_AXI_AWADDR = 5'h1C; S_AXI_AWVALID = 1'b1;
    @(negedge clock);
    S_AXI_AWVALID = 1'b0;
    check("late_aw_bvalid", 32'(S_AXI_BVALID), 32'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge clock);
    S_AXI_BREADY = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
